// File: rtl/tinycpu_pkg.sv
`default_nettype none
//============================================================================
// Module : tinycpu_pkg
// Brief  : Instruction type codes, ALU function codes and FSM states.
// Rev    : 1.0  initial release
//============================================================================
package tinycpu_pkg;

    typedef enum logic [2:0] {
        TYPE_ALU   = 3'b000,
        TYPE_LOAD  = 3'b001,
        TYPE_STORE = 3'b010,
        TYPE_IMM   = 3'b011,
        TYPE_JUMP  = 3'b100,
        TYPE_CJUMP = 3'b101,
        TYPE_HALT  = 3'b110,
        TYPE_NOP   = 3'b111
    } instr_type_e;

    typedef enum logic [2:0] {
        FN_ADD = 3'b000,
        FN_AND = 3'b001,
        FN_OR  = 3'b010,
        FN_XOR = 3'b011,
        FN_NOT = 3'b100,
        FN_EQ  = 3'b101,
        FN_LTU = 3'b110,
        FN_ASR = 3'b111
    } alu_fn_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MEM  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/tinycpu_if.sv
`default_nettype none
//============================================================================
// Module : tinycpu_if
// Brief  : Request/acknowledge data-memory bus between core and memory/IO.
// Rev    : 1.0  initial release
//============================================================================
interface tinycpu_if #(
    parameter int DW = 4,
    parameter int AW = 3
);
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    modport master (
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack
    );

    modport slave (
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack
    );
endinterface
`default_nettype wire

// File: rtl/tinycpu_alu.sv
`default_nettype none
//============================================================================
// Module : tinycpu_alu
// Brief  : Combinational ALU; compares return 0/1 zero-extended to DW.
// Rev    : 1.0  initial release
//============================================================================
module tinycpu_alu
    import tinycpu_pkg::*;
#(
    parameter int DW = 4
) (
    input  alu_fn_e       fn,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);

    always_comb begin
        y = '0;
        case (fn)
            FN_ADD: y = a + b;
            FN_AND: y = a & b;
            FN_OR:  y = a | b;
            FN_XOR: y = a ^ b;
            FN_NOT: y = ~a;
            FN_EQ:  y = DW'(a == b);
            FN_LTU: y = DW'(a < b);
            FN_ASR: y = {a[DW-1], a[DW-1:1]};
            default: y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/tinycpu_core.sv
`default_nettype none
//============================================================================
// Module : tinycpu_core
// Brief  : Single-issue TinySoC core with stalling data bus and HALT.
//          Macro TINYCPU_GPIO_EN maps [rs1][DW-1]=1 accesses to gpo/gpi.
// Rev    : 1.0  initial release
//============================================================================
module tinycpu_core
    import tinycpu_pkg::*;
#(
    parameter  int DW = 4,
    parameter  int RA = 2,
    parameter  int PW = 3,
    parameter  int AW = 3,
    localparam int IW = 3*RA + 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [PW-1:0] i_addr,
    input  logic [IW-1:0] instr,
    tinycpu_if.master     dbus,
    output logic [3:0]    gpo,
    input  logic [3:0]    gpi,
    output logic          halted
);

    state_e        r_state;
    logic [PW-1:0] r_pc;
    logic          r_d_req;
    logic          r_d_we;
    logic [AW-1:0] r_d_addr;
    logic [DW-1:0] r_d_wdata;
    logic [RA-1:0] r_mem_rd;
    logic [3:0]    r_gpo;
    logic          r_halted;
    logic [DW-1:0] r_regs [2**RA];

    instr_type_e   w_type;
    alu_fn_e       w_fn;
    logic [RA-1:0] w_rd;
    logic [RA-1:0] w_rs2;
    logic [RA-1:0] w_rs1;
    logic [RA-1:0] w_rb_addr;
    logic [DW-1:0] w_imm;
    logic [DW-1:0] w_ra;
    logic [DW-1:0] w_rb;
    logic [DW-1:0] w_alu_y;
    logic [PW-1:0] w_pc_inc;
    logic          w_gpio;
    logic          w_rf_we;
    logic [RA-1:0] w_rf_waddr;
    logic [DW-1:0] w_rf_wdata;

    assign w_type   = instr_type_e'(instr[IW-1 -: 3]);
    assign w_rd     = instr[IW-4 -: RA];
    assign w_rs2    = instr[IW-4-RA -: RA];
    assign w_rs1    = instr[3 +: RA];
    assign w_fn     = alu_fn_e'(instr[2:0]);
    assign w_imm    = DW'(instr[2*RA+2:0]);
    assign w_pc_inc = r_pc + PW'(1);

    // Second read port serves rs2, except for STORE where it supplies [rd].
    assign w_rb_addr = (w_type == TYPE_STORE) ? w_rd : w_rs2;
    assign w_ra      = r_regs[w_rs1];
    assign w_rb      = r_regs[w_rb_addr];

`ifdef TINYCPU_GPIO_EN
    assign w_gpio = w_ra[DW-1];
`else
    assign w_gpio = 1'b0;
`endif

    tinycpu_alu #(.DW(DW)) u_alu (
        .fn (w_fn),
        .a  (w_ra),
        .b  (w_rb),
        .y  (w_alu_y)
    );

    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_waddr = w_rd;
        w_rf_wdata = w_alu_y;
        case (r_state)
            ST_RUN: begin
                if (en) begin
                    if (w_type == TYPE_ALU) begin
                        w_rf_we = 1'b1;
                    end else if (w_type == TYPE_IMM) begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = w_imm;
                    end else if (w_type == TYPE_LOAD && w_gpio) begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = DW'(gpi);
                    end
                end
            end
            ST_MEM: begin
                if (dbus.d_ack && !r_d_we) begin
                    w_rf_we    = 1'b1;
                    w_rf_waddr = r_mem_rd;
                    w_rf_wdata = dbus.d_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**RA; i++) r_regs[i] <= '0;
        end else if (w_rf_we) begin
            r_regs[w_rf_waddr] <= w_rf_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_pc      <= '0;
            r_d_req   <= 1'b0;
            r_d_we    <= 1'b0;
            r_d_addr  <= '0;
            r_d_wdata <= '0;
            r_mem_rd  <= '0;
            r_gpo     <= '0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (en) begin
                        case (w_type)
                            TYPE_JUMP:  r_pc <= PW'(w_ra);
                            TYPE_CJUMP: r_pc <= (w_rb != '0) ? PW'(w_ra) : w_pc_inc;
                            TYPE_HALT: begin
                                r_halted <= 1'b1;
                                r_state  <= ST_HALT;
                            end
                            TYPE_LOAD, TYPE_STORE: begin
                                if (w_gpio) begin
                                    if (w_type == TYPE_STORE) r_gpo <= 4'(w_rb);
                                    r_pc <= w_pc_inc;
                                end else begin
                                    // pc stays frozen until the bus acknowledges
                                    r_d_req   <= 1'b1;
                                    r_d_we    <= (w_type == TYPE_STORE);
                                    r_d_addr  <= w_ra[AW-1:0];
                                    r_d_wdata <= w_rb;
                                    r_mem_rd  <= w_rd;
                                    r_state   <= ST_MEM;
                                end
                            end
                            default: r_pc <= w_pc_inc;
                        endcase
                    end
                end
                ST_MEM: begin
                    if (dbus.d_ack) begin
                        r_d_req <= 1'b0;
                        r_pc    <= w_pc_inc;
                        r_state <= ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i_addr       = r_pc;
    assign dbus.d_req   = r_d_req;
    assign dbus.d_we    = r_d_we;
    assign dbus.d_addr  = r_d_addr;
    assign dbus.d_wdata = r_d_wdata;
    assign gpo          = r_gpo;
    assign halted       = r_halted;

endmodule
`default_nettype wire

// File: doc/tinycpu_core.md
# tinycpu_core

- Parametrised second-generation core for the TinySoC: a single-issue accumulator-free RISC core.
- Fixes and generalises the 4-bit core:
  - configurable data, register, PC and data-address widths;
  - stalling request/acknowledge data-memory port;
  - working conditional jump and unsigned less-than;
  - HALT instruction;
  - optionally compiled memory-mapped GPIO.
- Sits between the TinySoC instruction store (combinational read) and data memory/IO.

## Interface
- `DW`, 4: data/register width.
- `RA`, 2: register-address width; register file has 2^RA entries.
- `PW`, 3: PC width; instruction memory depth 2^PW.
- `AW`, 3: data-address width; must satisfy AW < DW.
- `IW`, derived = 3*RA+6: instruction width. Not overridable.
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `en` in 1: run enable (ROM-load done).
- `i_addr` out PW: instruction address = pc.
- `instr` in IW: instruction at `i_addr`, valid same cycle.
- `d_req` out 1: data request, registered.
- `d_we` out 1: 1 = store, 0 = load; valid while `d_req`.
- `d_addr` out AW: data address; valid while `d_req`.
- `d_wdata` out DW: store data.
- `d_rdata` in DW: load data; sampled when `d_ack`.
- `d_ack` in 1: completes the request, one cycle pulse.
- `gpo` out 4: general-purpose output register.
- `gpi` in 4: general-purpose input.
- `halted` out 1: core stopped by HALT.

## Operation
- Field layout: `[IW-1:IW-3]` type, then rd, rs2, rs1 (RA bits each), `[2:0]` fn. Immediate = low 2*RA+3 bits, zero-extended or truncated to DW.
- Type codes:
  - 000 ALU: rd <= f([rs1],[rs2]). fn: ADD (mod 2^DW), AND, OR, XOR, NOT [rs1], EQ, LTU (unsigned), ASR by 1. EQ and LTU give 0/1 zero-extended.
  - 001 LOAD: rd <= mem[[rs1][AW-1:0]].
  - 010 STORE: mem[[rs1][AW-1:0]] <= [rd].
  - 011 IMM: rd <= imm.
  - 100 JUMP: pc <= [rs1], zero-extended or truncated to PW.
  - 101 CJUMP: if [rs2] != 0 then pc <= [rs1], else pc+1.
  - 110 HALT.
  - 111: NOP.
- All registers, including r0, are ordinary registers.
- FSM states: RUN, MEM, HALT.
  - RUN, en=0: nothing changes.
  - RUN, en=1, ALU/IMM/JUMP/CJUMP/NOP: retire in one cycle.
  - RUN, en=1, LOAD/STORE on the bus: latch d_we/d_addr/d_wdata and rd into registers, set d_req, go to MEM. pc is not advanced.
  - MEM: hold all d_* stable until d_ack. On d_ack: clear d_req; for a load, write rd from d_rdata; pc+1; go to RUN. `en` is ignored in MEM.
  - RUN, HALT: set halted, go to HALT.
  - HALT: only reset leaves it.
- PC wraps from 2^PW-1 to 0.
- d_ack outside MEM is ignored.

## Timing
- Reset values: pc=0, all regs 0, gpo=0, d_req=0, d_we=0, d_addr=0, d_wdata=0, halted=0, state RUN.
- Reset asserted mid-MEM abandons the request at once: d_req=0 asynchronously.
- Latency:
  - ALU/IMM/jump: 1 cycle.
  - Bus LOAD/STORE: 1 + n cycles, where n ≥ 1 is the cycle d_ack arrives, counted from the first d_req-high cycle.
  - Minimum bus LOAD/STORE is 2 cycles.
- d_req rises the cycle after decode. The instruction must stay stable because pc is frozen.
- The register write for a load is visible to the next instruction.

## Configuration
- Macro: `TINYCPU_GPIO_EN`.
- Defined: a LOAD/STORE with [rs1][DW-1]=1 is a GPIO access and retires in 1 cycle with no bus request.
  - STORE: gpo <= [rd][3:0], zero-padded when DW < 4.
  - LOAD: rd <= gpi, zero-extended or truncated to DW.
- Undefined: every LOAD/STORE uses the bus; gpo is tied to 0 and gpi is unused.

## Structure
- Package `tinycpu_pkg` holds:
  - type codes (TYPE_ALU..TYPE_NOP);
  - ALU fn codes;
  - FSM state enum.
- Sub-module `tinycpu_alu`: combinational, parametrised by DW.
- Register file: inline array, 2 read ports, 1 write port.

## Test plan
- IMM r1=5, IMM r2=3, ALU ADD r3=r1+r2 (DW=4) -> r3=8 after 3 cycles. Then IMM r1=15, ADD r3=r1+r1 -> r3=14 (wrap).
- LTU with [rs1]=2, [rs2]=9 -> rd=1. EQ with 9, 9 -> 1. ASR of 4'b1010 -> 4'b1101.
- STORE with d_ack delayed 3 cycles:
  - d_req high for exactly 3 cycles, d_addr/d_wdata stable throughout;
  - pc advances 1 cycle after ack.
  - LOAD then returns d_rdata=0xA in rd.
- CJUMP with [rs2]=0 -> pc+1. With [rs2]=1, [rs1]=6 -> pc=6. JUMP from pc=7 with no target register set -> 0.
- With TINYCPU_GPIO_EN, DW=4:
  - STORE to [rs1]=8, [rd]=0x5 -> gpo=5 next cycle, d_req never high.
  - LOAD with gpi=0x3 -> rd=3.
- HALT -> halted=1 and pc frozen despite en=1. rst_n low mid-MEM -> d_req=0 immediately, pc=0.
